insn_sequencer: RTL
===================

# insn_sequencer

Multicycle control sequencer for the processor core. Takes the 5-bit instruction opcode and ALU-op fields, steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables. It also handles the instruction/data memory ready handshakes and the multiply/divide unit start/done handshake. It sits between the instruction register and the datapath, replacing per-opcode combinational control with a single state machine.

## Interface
- `MD_TIMEOUT`, default 64: maximum number of cycles spent in MDWAIT before the block traps. Legal range 2..255.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ctrl_opcode` in 5: instruction bits [31:27]; sampled in DECODE.
- `ctrl_aluop` in 5: instruction bits [6:2]; sampled in DECODE.
- `imem_ready` in 1: instruction word available this cycle.
- `dmem_ready` in 1: data access completes this cycle.
- `md_ready` in 1: multiply/divide result valid.
- `ctrl_imem_rd` out 1: instruction fetch request.
- `ctrl_ir_we` out 1: load the instruction register.
- `ctrl_pc_we` out 1: PC update strobe.
- `ctrl_jump` out 1: PC source is the jump target (otherwise PC+1).
- `ctrl_alu_imm` out 1: ALU operand B is the sign-extended immediate.
- `ctrl_dmem_rd` out 1: data memory read request.
- `ctrl_dmem_we` out 1: data memory write request.
- `ctrl_md_start` out 1: one-cycle start pulse to the multiply/divide unit.
- `ctrl_reg_we` out 1: register file write enable.
- `ctrl_wb_sel` out 2: writeback source. 0 = ALU, 1 = memory, 2 = multiply/divide.
- `exc_illegal` out 1: sticky illegal-instruction / timeout flag.
- `state` out 3: current state encoding.
- `instret` out 32: retired-instruction counter.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, MDWAIT=6, TRAP=7.
- Reset:
  - State goes to IDLE.
  - All outputs are 0, `instret` is 0, and the MDWAIT timer is 0.
  - IDLE always moves to FETCH on the next cycle.
- FETCH:
  - Asserts `ctrl_imem_rd`.
  - Holds in FETCH while `imem_ready`=0.
  - When `imem_ready`=1: pulses `ctrl_ir_we` and `ctrl_pc_we` (with `ctrl_jump`=0), then moves to DECODE.
- DECODE: latches the opcode class internally and moves to EXEC. Supported opcodes:
  - R-type (00000)
  - addi (00101)
  - sw (00111)
  - lw (01000)
  - j (00001)
  - Any other opcode moves to TRAP.
- EXEC:
  - R-type, `ctrl_aluop` not 00110 or 00111: goes to WB.
  - R-type mul (00110) or div (00111): pulses `ctrl_md_start` for exactly one cycle and goes to MDWAIT.
  - addi: `ctrl_alu_imm`=1, goes to WB.
  - lw and sw: `ctrl_alu_imm`=1, goes to MEM.
  - j: `ctrl_pc_we`=1 and `ctrl_jump`=1; the instruction retires and the state returns to FETCH.
- MEM:
  - lw asserts `ctrl_dmem_rd`; sw asserts `ctrl_dmem_we`.
  - Holds until `dmem_ready`=1.
  - Then lw goes to WB; sw retires and goes to FETCH.
- MDWAIT:
  - The timer increments every cycle.
  - `md_ready`=1 goes to WB.
  - If the timer reaches `MD_TIMEOUT` with `md_ready` still 0, goes to TRAP.
  - `md_ready` and timeout in the same cycle: `md_ready` wins.
- WB:
  - `ctrl_reg_we`=1, with `ctrl_wb_sel` = 0 (ALU), 1 (lw) or 2 (mul/div).
  - The instruction retires and the state returns to FETCH.
- TRAP:
  - `exc_illegal`=1.
  - All enables are 0 and the state stays in TRAP until `reset_n` is asserted.
- Retire: `instret` increments by 1, wrapping from 0xFFFFFFFF to 0.
- Output style:
  - All control outputs are Moore-decoded from the registered state plus the latched class.
  - The exception: `ctrl_ir_we` and `ctrl_pc_we` in FETCH are gated by `imem_ready`.
- Ready inputs arriving in states that do not wait on them are ignored.

## Timing
Cycle counts assume ready inputs held high:
- R-type ALU and addi: 4 cycles (F, D, E, W).
- lw: 5 cycles.
- sw: 4 cycles.
- j: 3 cycles.
- mul/div: 4 + N cycles, where `md_ready` arrives N ≥ 1 cycles after the start pulse.

Other timing rules:
- Each cycle of low `imem_ready` or `dmem_ready` adds exactly one cycle.
- Asserting `reset_n` mid-instruction (including MEM or MDWAIT) forces IDLE immediately. There is no partial retire and no pending write.
- `state` and all outputs reflect the reset values while `reset_n`=0.

## Configuration
- `INSN_SEQ_MULTDIV_EN` defined:
  - MDWAIT, `ctrl_md_start`, the MDWAIT timer and `ctrl_wb_sel`=2 are implemented.
- `INSN_SEQ_MULTDIV_EN` undefined:
  - R-type aluop 00110 or 00111 is illegal and goes from DECODE to TRAP.
  - `ctrl_md_start` is tied to 0 and MDWAIT is unreachable.
  - `md_ready` is ignored.

## Test plan
- Reset then add (opcode 00000, aluop 00000), all ready inputs high: states 0,1,2,3,5,1; one `ctrl_reg_we` pulse with `ctrl_wb_sel`=0; `instret`=1.
- lw with `dmem_ready` low for 3 cycles: MEM held 4 cycles with `ctrl_dmem_rd`=1; WB has `ctrl_wb_sel`=1; total 8 cycles.
- j: `ctrl_pc_we`=1 and `ctrl_jump`=1 in EXEC only; no `ctrl_reg_we`; the next cycle is FETCH.
- mul with `md_ready` 5 cycles after the start pulse: exactly one `ctrl_md_start` pulse, then WB with `ctrl_wb_sel`=2.
- Same mul with `md_ready` never asserted: TRAP after 64 MDWAIT cycles.
- Opcode 11111: TRAP with `exc_illegal`=1 and no enables thereafter; `reset_n` pulse returns to IDLE with `exc_illegal`=0.

Source files
------------

// File: rtl/insn_sequencer.sv
// insn_sequencer: multicycle fetch/decode/execute/memory/writeback control FSM.
// Define INSN_SEQ_MULTDIV_EN to enable the multiply/divide handshake (MDWAIT state).
module insn_sequencer #(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  ctrl_opcode,
    input  logic [4:0]  ctrl_aluop,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        md_ready,
    output logic        ctrl_imem_rd,
    output logic        ctrl_ir_we,
    output logic        ctrl_pc_we,
    output logic        ctrl_jump,
    output logic        ctrl_alu_imm,
    output logic        ctrl_dmem_rd,
    output logic        ctrl_dmem_we,
    output logic        ctrl_md_start,
    output logic        ctrl_reg_we,
    output logic [1:0]  ctrl_wb_sel,
    output logic        exc_illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_MDWAIT = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_MD, CLS_ADDI, CLS_LW, CLS_SW, CLS_J
    } cls_t;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    state_t cur;
    cls_t   cls;
    cls_t   dec_cls;
    logic   dec_legal;

`ifdef INSN_SEQ_MULTDIV_EN
    logic [7:0] md_timer;
`else
    logic md_unused;
    assign md_unused = md_ready | (MD_TIMEOUT == 0);
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_cls   = CLS_ALU;
        dec_legal = 1'b1;
        case (ctrl_opcode)
            OP_RTYPE: begin
                if (ctrl_aluop == ALU_MUL || ctrl_aluop == ALU_DIV) begin
`ifdef INSN_SEQ_MULTDIV_EN
                    dec_cls = CLS_MD;
`else
                    dec_legal = 1'b0;
`endif
                end
            end
            OP_ADDI: dec_cls = CLS_ADDI;
            OP_SW:   dec_cls = CLS_SW;
            OP_LW:   dec_cls = CLS_LW;
            OP_J:    dec_cls = CLS_J;
            default: dec_legal = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur     <= S_IDLE;
            cls     <= CLS_ALU;
            instret <= '0;
`ifdef INSN_SEQ_MULTDIV_EN
            md_timer <= '0;
`endif
        end else begin
            case (cur)
                S_IDLE:   cur <= S_FETCH;
                S_FETCH:  if (imem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    cls <= dec_cls;
                    cur <= dec_legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    case (cls)
                        CLS_J: begin
                            cur     <= S_FETCH;
                            instret <= instret + 32'd1;
                        end
                        CLS_LW, CLS_SW: cur <= S_MEM;
`ifdef INSN_SEQ_MULTDIV_EN
                        CLS_MD: begin
                            md_timer <= '0;
                            cur      <= S_MDWAIT;
                        end
`endif
                        default: cur <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (cls == CLS_SW) begin
                            cur     <= S_FETCH;
                            instret <= instret + 32'd1;
                        end else begin
                            cur <= S_WB;
                        end
                    end
                end
                S_MDWAIT: begin
`ifdef INSN_SEQ_MULTDIV_EN
                    // A result arriving on the final timer cycle still completes normally.
                    md_timer <= md_timer + 8'd1;
                    if (md_ready)
                        cur <= S_WB;
                    else if (md_timer == 8'(MD_TIMEOUT - 1))
                        cur <= S_TRAP;
`else
                    cur <= S_TRAP;
`endif
                end
                S_WB: begin
                    cur     <= S_FETCH;
                    instret <= instret + 32'd1;
                end
                S_TRAP:  cur <= S_TRAP;
                default: cur <= S_IDLE;
            endcase
        end
    end

    // Moore decode from the state register and latched class; only the fetch strobes see imem_ready.
    always_comb begin
        ctrl_imem_rd  = 1'b0;
        ctrl_ir_we    = 1'b0;
        ctrl_pc_we    = 1'b0;
        ctrl_jump     = 1'b0;
        ctrl_alu_imm  = 1'b0;
        ctrl_dmem_rd  = 1'b0;
        ctrl_dmem_we  = 1'b0;
        ctrl_md_start = 1'b0;
        ctrl_reg_we   = 1'b0;
        ctrl_wb_sel   = 2'd0;
        exc_illegal   = 1'b0;
        case (cur)
            S_FETCH: begin
                ctrl_imem_rd = 1'b1;
                ctrl_ir_we   = imem_ready;
                ctrl_pc_we   = imem_ready;
            end
            S_EXEC: begin
                case (cls)
`ifdef INSN_SEQ_MULTDIV_EN
                    CLS_MD: ctrl_md_start = 1'b1;
`endif
                    CLS_ADDI, CLS_LW, CLS_SW: ctrl_alu_imm = 1'b1;
                    CLS_J: begin
                        ctrl_pc_we = 1'b1;
                        ctrl_jump  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl_dmem_rd = (cls == CLS_LW);
                ctrl_dmem_we = (cls == CLS_SW);
            end
            S_WB: begin
                ctrl_reg_we = 1'b1;
                if (cls == CLS_LW)
                    ctrl_wb_sel = 2'd1;
                else if (cls == CLS_MD)
                    ctrl_wb_sel = 2'd2;
            end
            S_TRAP:  exc_illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = cur;

endmodule
